// File: rtl/video_gen_pkg.sv
// video_gen_pkg: pattern-mode encoding, colour-bar table and colour expansion helper
package video_gen_pkg;
  typedef enum logic [1:0] {MODE_SOLID, MODE_BARS, MODE_CHECK, MODE_GRAD} mode_e;
  localparam int COLOR_W_MAX = 32;
  localparam logic [2:0] BAR_CODES [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
  function automatic logic [3*COLOR_W_MAX-1:0] expand_code(input logic [2:0] code, input int w);
    logic [3*COLOR_W_MAX-1:0] res;
    res = '0;
    for (int i = 0; i < 3; i++)
      for (int b = 0; b < COLOR_W_MAX; b++)
        if (b < w) res[i*w+b] = code[i];
    return res;
  endfunction
endpackage

// File: rtl/video_timing_core.sv
// video_timing_core: pixel/line counters, sync and DE decode, frame strobes and colour-bar index
module video_timing_core #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] x_o,
  output logic [CNT_W-1:0] y_o,
  output logic             de_o,
  output logic             hs_o,
  output logic             vs_o,
  output logic             origin_o,
  output logic             eof_o,
  output logic [2:0]       bar_o
);
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W = H_ACTIVE / 8;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d, bpx_q, bpx_d;
  logic [2:0] bar_q, bar_d;
  logic x_end, y_end, bstep;
  // the last bar never advances, so it absorbs any H_ACTIVE remainder
  always_comb begin
    x_end = x_q == CNT_W'(H_TOT - 1);
    y_end = y_q == CNT_W'(V_TOT - 1);
    x_d = x_end ? '0 : x_q + CNT_W'(1);
    y_d = x_end ? (y_end ? '0 : y_q + CNT_W'(1)) : y_q;
    bstep = x_q < CNT_W'(H_ACTIVE) && bpx_q == CNT_W'(BAR_W - 1) && bar_q != 3'd7;
    bar_d = x_end ? '0 : bar_q + 3'(bstep);
    bpx_d = (x_end || bstep) ? '0 : bpx_q + CNT_W'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
      bpx_q <= '0;
      bar_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      bpx_q <= bpx_d;
      bar_q <= bar_d;
    end
  end
  assign x_o = x_q;
  assign y_o = y_q;
  assign bar_o = bar_q;
  assign de_o = x_q < CNT_W'(H_ACTIVE) && y_q < CNT_W'(V_ACTIVE);
  assign hs_o = x_q >= CNT_W'(H_ACTIVE + H_FP) && x_q < CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  assign vs_o = y_q >= CNT_W'(V_ACTIVE + V_FP) && y_q < CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  assign origin_o = x_q == '0 && y_q == '0;
  assign eof_o = x_end && y_end;
endmodule

// File: rtl/hdmi_video_gen.sv
// hdmi_video_gen: generic-timing HDMI parallel video source with selectable test patterns
module hdmi_video_gen
  import video_gen_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int COLOR_W = 8,
  parameter int CNT_W = 12,
  parameter int CHECK_LOG2 = 5
) (
  input  logic                 CLK_PX,
  input  logic                 RST,
  input  logic [1:0]           MODE,
  input  logic [3*COLOR_W-1:0] SOLID_COLOR,
  output logic                 HDMI_CLK,
  output logic                 DE,
  output logic                 HSYNC,
  output logic                 VSYNC,
  output logic [COLOR_W-1:0]   RED,
  output logic [COLOR_W-1:0]   GREEN,
  output logic [COLOR_W-1:0]   BLUE,
  output logic [CNT_W-1:0]     PX_X,
  output logic [CNT_W-1:0]     PX_Y,
  output logic                 SOF,
  output logic [15:0]          FRAME_CNT
);
  localparam longint H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam longint V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_ACTIVE == 0 || V_FP == 0 ||
      V_SYNC == 0 || V_BP == 0 || H_ACTIVE < 8 || COLOR_W < 1 || COLOR_W > CNT_W ||
      COLOR_W > COLOR_W_MAX || CHECK_LOG2 >= CNT_W || (64'd1 << CNT_W) < H_TOT ||
      (64'd1 << CNT_W) < V_TOT) begin : g_bad_params
    $error("hdmi_video_gen: invalid parameter set");
  end
  logic [CNT_W-1:0] x, y;
  logic de, hs, vs, origin, eof;
  logic [2:0] bar;
  video_timing_core #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .CNT_W(CNT_W)
  ) u_timing (
    .clk(CLK_PX), .rst(RST), .x_o(x), .y_o(y), .de_o(de), .hs_o(hs), .vs_o(vs),
    .origin_o(origin), .eof_o(eof), .bar_o(bar)
  );
  mode_e mode_q, mode_d;
  logic [3*COLOR_W-1:0] solid_q, solid_d, pat, rgb_q, rgb_d;
  logic [15:0] frame_q, frame_d;
  logic de_q, hs_q, vs_q, sof_q;
  logic [CNT_W-1:0] px_x_q, px_y_q;
  // at (0,0) the fresh inputs are used directly so the first pixel already reflects them
  always_comb begin
    mode_d = origin ? mode_e'(MODE) : mode_q;
    solid_d = origin ? SOLID_COLOR : solid_q;
    pat = mode_d == MODE_SOLID ? solid_d :
          mode_d == MODE_BARS  ? (3*COLOR_W)'(expand_code(BAR_CODES[bar], COLOR_W)) :
          mode_d == MODE_CHECK ? {3*COLOR_W{x[CHECK_LOG2] ^ y[CHECK_LOG2]}} :
                                 {COLOR_W'(x), COLOR_W'(y), COLOR_W'(frame_q)};
    rgb_d = de ? pat : '0;
    frame_d = eof ? frame_q + 16'd1 : frame_q;
  end
  always_ff @(posedge CLK_PX) begin
    if (RST) begin
      mode_q <= MODE_SOLID;
      solid_q <= '0;
      rgb_q <= '0;
      frame_q <= '0;
      de_q <= 1'b0;
      hs_q <= ~H_SYNC_POL;
      vs_q <= ~V_SYNC_POL;
      sof_q <= 1'b0;
      px_x_q <= '0;
      px_y_q <= '0;
    end else begin
      mode_q <= mode_d;
      solid_q <= solid_d;
      rgb_q <= rgb_d;
      frame_q <= frame_d;
      de_q <= de;
      hs_q <= hs ? H_SYNC_POL : ~H_SYNC_POL;
      vs_q <= vs ? V_SYNC_POL : ~V_SYNC_POL;
      sof_q <= origin;
      px_x_q <= x;
      px_y_q <= y;
    end
  end
  assign HDMI_CLK = CLK_PX;
  assign DE = de_q;
  assign HSYNC = hs_q;
  assign VSYNC = vs_q;
  assign {RED, GREEN, BLUE} = rgb_q;
  assign PX_X = px_x_q;
  assign PX_Y = px_y_q;
  assign SOF = sof_q;
  assign FRAME_CNT = frame_q;
endmodule

// File: tb/tb_hdmi_video_gen.sv
// tb_hdmi_video_gen: scoreboard bench against a frame-position reference model
module tb_hdmi_video_gen;
  localparam int HA = 8, HF = 2, HS = 3, HB = 2, VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB, FT = HT * VT, BAR_W = HA / 8;
  typedef struct packed {
    logic de, hs, vs;
    logic [23:0] rgb;
    logic [11:0] px, py;
    logic sof;
    logic [15:0] fc;
  } exp_t;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00, 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [23:0] col = 24'h112233;
  logic hdmi_clk, de, hsync, vsync, sof, p_clk, p_de, p_hs, p_vs, p_sof;
  logic [7:0] red, green, blue, p_r, p_g, p_b;
  logic [11:0] px_x, px_y, p_x, p_y;
  logic [15:0] fcnt, p_fc;
  exp_t sb[$];
  int tests = 0, fails = 0;
  int p = 0, frame = 0;
  logic [1:0] sh_mode = 2'd0;
  logic [23:0] sh_col = '0;
  always #5 clk = ~clk;
  hdmi_video_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
    .V_SYNC(VS), .V_BP(VB), .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .COLOR_W(8), .CNT_W(12),
    .CHECK_LOG2(1)) dut (
    .CLK_PX(clk), .RST(rst), .MODE(mode), .SOLID_COLOR(col), .HDMI_CLK(hdmi_clk), .DE(de),
    .HSYNC(hsync), .VSYNC(vsync), .RED(red), .GREEN(green), .BLUE(blue), .PX_X(px_x),
    .PX_Y(px_y), .SOF(sof), .FRAME_CNT(fcnt));
  hdmi_video_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
    .V_SYNC(VS), .V_BP(VB), .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .COLOR_W(8), .CNT_W(12),
    .CHECK_LOG2(1)) dut_p (
    .CLK_PX(clk), .RST(rst), .MODE(mode), .SOLID_COLOR(col), .HDMI_CLK(p_clk), .DE(p_de),
    .HSYNC(p_hs), .VSYNC(p_vs), .RED(p_r), .GREEN(p_g), .BLUE(p_b), .PX_X(p_x),
    .PX_Y(p_y), .SOF(p_sof), .FRAME_CNT(p_fc));

  task automatic drive(input logic r, input logic [1:0] m, input logic [23:0] c);
    exp_t e;
    int x, y;
    @(negedge clk);
    rst = r;
    mode = m;
    col = c;
    e = '0;
    if (r) begin
      e.hs = 1'b1;
      e.vs = 1'b1;
      p = 0;
      frame = 0;
    end else begin
      x = p % HT;
      y = p / HT;
      if (p == 0) begin
        sh_mode = m;
        sh_col = c;
      end
      e.de = x < HA && y < VA;
      e.hs = !(x >= HA + HF && x < HA + HF + HS);
      e.vs = !(y >= VA + VF && y < VA + VF + VS);
      case (sh_mode)
        2'd0: e.rgb = sh_col;
        2'd1: e.rgb = bars[(x / BAR_W > 7) ? 7 : x / BAR_W];
        2'd2: e.rgb = (((x >> 1) ^ (y >> 1)) & 1) != 0 ? 24'hFFFFFF : 24'h0;
        default: e.rgb = {8'(x), 8'(y), 8'(frame)};
      endcase
      if (!e.de) e.rgb = '0;
      e.px = 12'(x);
      e.py = 12'(y);
      e.sof = p == 0;
      if (p == FT - 1) frame = (frame + 1) % 65536;
      e.fc = 16'(frame);
      p = (p + 1) % FT;
    end
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e, g;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      g = '{de, hsync, vsync, {red, green, blue}, px_x, px_y, sof, fcnt};
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL pixel t=%0t: got de=%b hs=%b vs=%b rgb=%h x=%0d y=%0d sof=%b fc=%0d, want de=%b hs=%b vs=%b rgb=%h x=%0d y=%0d sof=%b fc=%0d",
          $time, g.de, g.hs, g.vs, g.rgb, g.px, g.py, g.sof, g.fc, e.de, e.hs, e.vs, e.rgb, e.px, e.py, e.sof, e.fc);
      end
      tests++;
      if ({p_hs, p_vs} !== {~e.hs, ~e.vs}) begin
        fails++;
        $display("FAIL inverted_sync t=%0t: got hs=%b vs=%b want hs=%b vs=%b", $time, p_hs, p_vs, ~e.hs, ~e.vs);
      end
      tests++;
      if (hdmi_clk !== 1'b1) begin
        fails++;
        $display("FAIL hdmi_clk t=%0t: got %b want 1", $time, hdmi_clk);
      end
    end
  end

  initial begin
    logic [1:0] m;
    logic [23:0] c;
    repeat (3) drive(1'b1, 2'd0, 24'h112233);
    for (int k = 0; k < FT; k++) drive(1'b0, (k >= 2 * HT + 3) ? 2'd1 : 2'd0, 24'h112233);
    for (int k = 0; k < FT; k++) drive(1'b0, 2'd1, (k > 40) ? 24'hABCDEF : 24'h112233);
    for (int k = 0; k < FT; k++) drive(1'b0, 2'd2, 24'h112233);
    for (int k = 0; k < 2 * FT; k++) drive(1'b0, 2'd3, 24'h112233);
    for (int k = 0; k < 3 * HT + 9; k++) drive(1'b0, 2'd3, 24'h112233);
    drive(1'b1, 2'd3, 24'h112233);
    for (int k = 0; k < FT; k++) drive(1'b0, 2'd0, 24'h112233);
    m = 2'd0;
    c = 24'h112233;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(15) == 0) m = 2'($urandom_range(3));
      if ($urandom_range(15) == 0) c = 24'($urandom);
      drive($urandom_range(399) == 0, m, c);
    end
    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
